// File: rtl/eth_rx_frame_buf.sv
// Receive frame buffer: stores rx bytes, checks CRC-32 and length at eof, commits good frames or
// rolls them back, then replays committed frames on a valid/ready stream with optional FCS strip.
`timescale 1ns/1ps
module eth_rx_frame_buf #(
    parameter int ADDR_W    = 11,
    parameter int LEN_W     = 4,
    parameter int MIN_LEN   = 64,
    parameter int STRIP_FCS = 1
) (
    input  logic              clk_mac,
    input  logic              rst_n,
    input  logic              rx_vld,
    input  logic [7:0]        rx_dat,
    input  logic              rx_sof,
    input  logic              rx_eof,
    output logic              m_vld,
    output logic [7:0]        m_dat,
    output logic              m_sof,
    output logic              m_eof,
    output logic [ADDR_W-1:0] m_len,
    input  logic              m_rdy,
    output logic [15:0]       cnt_ok,
    output logic [15:0]       cnt_drop
);
    localparam int PW = ADDR_W + 1;
    localparam int LW = LEN_W + 1;
    localparam logic [PW-1:0] DEPTH       = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [LW-1:0] LF_DEPTH    = {1'b1, {LEN_W{1'b0}}};
    localparam logic [PW-1:0] FCS_ADJ     = PW'(4 * STRIP_FCS);
    localparam logic [PW-1:0] MIN_L       = PW'(MIN_LEN);
    localparam logic [31:0]   CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0]   CRC_RESIDUE = 32'hDEBB_20E3;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_DROP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_LOAD = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] dat);
        logic [31:0] c;
        c = crc ^ {24'd0, dat};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic [PW-1:0]     lf_mem [0:(1<<LEN_W)-1];

    logic [1:0]        wstate_q, wstate_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     wr_cmt_q, wr_cmt_d;
    logic [PW-1:0]     flen_q, flen_d;
    logic [31:0]       crc_q, crc_d;
    logic [15:0]       ok_q, ok_d;
    logic [15:0]       drop_q, drop_d;
    logic [LW-1:0]     lf_wp_q, lf_wp_d;
    logic [LW-1:0]     lf_rp_q, lf_rp_d;

    logic [1:0]        rstate_q, rstate_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     rem_q, rem_d;
    logic [ADDR_W-1:0] m_len_q, m_len_d;
    logic              pend_q, pend_sof_q, pend_eof_q;
    logic [7:0]        ram_q;
    logic              sk_vld_q, sk_vld_d, sk_sof_q, sk_sof_d, sk_eof_q, sk_eof_d;
    logic [7:0]        sk_dat_q, sk_dat_d;
    logic              m_vld_q, m_vld_d, m_sof_q, m_sof_d, m_eof_q, m_eof_d;
    logic [7:0]        m_dat_q, m_dat_d;

    logic              frame_byte, buf_full, good, wr_en, push, lf_full, lf_empty;
    logic [PW-1:0]     base, cur_len, push_len;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       crc_nxt;
    logic [1:0]        n_drop;
    logic [PW-1:0]     lf_head;
    logic              lf_pop, issue, iss_sof, iss_eof, pop_out, eof_xfer, out_load;
    logic [2:0]        occ;

    assign lf_full  = (lf_wp_q - lf_rp_q) == LF_DEPTH;
    assign lf_empty = (lf_wp_q == lf_rp_q);
    assign lf_head  = lf_mem[lf_rp_q[LEN_W-1:0]];

    // Write side: a sof byte always restarts at the commit point, which also rolls back any open frame.
    always_comb begin
        wstate_d   = wstate_q;
        wr_ptr_d   = wr_ptr_q;
        wr_cmt_d   = wr_cmt_q;
        flen_d     = flen_q;
        crc_d      = crc_q;
        ok_d       = ok_q;
        n_drop     = 2'd0;
        wr_en      = 1'b0;
        push       = 1'b0;
        frame_byte = rx_vld && (rx_sof || wstate_q == W_DATA);
        base       = rx_sof ? wr_cmt_q : wr_ptr_q;
        wr_addr    = base[ADDR_W-1:0];
        cur_len    = rx_sof ? PW'(1) : flen_q + PW'(1);
        push_len   = cur_len - FCS_ADJ;
        crc_nxt    = crc32_byte(rx_sof ? CRC_INIT : crc_q, rx_dat);
        buf_full   = (base - rd_ptr_q) == DEPTH;
        good       = (cur_len >= MIN_L) && (crc_nxt == CRC_RESIDUE) && !lf_full;

        if (rx_vld && rx_sof && wstate_q == W_DATA) begin
            n_drop = n_drop + 2'd1;
        end
        if (frame_byte) begin
            if (buf_full) begin
                wr_ptr_d  = wr_cmt_q;
                n_drop    = n_drop + 2'd1;
                wstate_d  = rx_eof ? W_IDLE : W_DROP;
            end else begin
                wr_en    = 1'b1;
                wr_ptr_d = base + PW'(1);
                flen_d   = cur_len;
                crc_d    = crc_nxt;
                wstate_d = W_DATA;
                if (rx_eof) begin
                    wstate_d = W_IDLE;
                    if (good) begin
                        // Commit point includes the FCS bytes; the reader skips them after eof.
                        wr_cmt_d = base + PW'(1);
                        push     = 1'b1;
                        ok_d     = ok_q + 16'd1;
                    end else begin
                        wr_ptr_d = wr_cmt_q;
                        n_drop   = n_drop + 2'd1;
                    end
                end
            end
        end else if (rx_vld && rx_eof && wstate_q == W_DROP) begin
            wstate_d = W_IDLE;
        end
        drop_d  = drop_q + {14'd0, n_drop};
        lf_wp_d = lf_wp_q + LW'(push);
    end

    assign pop_out  = m_vld_q && m_rdy;
    assign eof_xfer = pop_out && m_eof_q;
    assign occ      = 3'(m_vld_q) + 3'(sk_vld_q) + 3'(pend_q) - 3'(pop_out);

    // Read side: a RAM read is issued only when the output and prefetch registers can absorb it.
    always_comb begin
        rstate_d = rstate_q;
        rd_ptr_d = rd_ptr_q;
        rem_d    = rem_q;
        m_len_d  = m_len_q;
        issue    = 1'b0;
        iss_sof  = 1'b0;
        iss_eof  = 1'b0;
        lf_pop   = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (!lf_empty) lf_pop = 1'b1;
            end
            R_LOAD: begin
                issue    = 1'b1;
                iss_sof  = 1'b1;
                rstate_d = R_DATA;
            end
            R_DATA: begin
                if (rem_q != '0 && occ <= 3'd1) issue = 1'b1;
                if (eof_xfer) begin
                    rd_ptr_d = rd_ptr_q + FCS_ADJ;
                    rstate_d = R_IDLE;
                    if (!lf_empty) lf_pop = 1'b1;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        if (issue) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            rem_d    = rem_q - PW'(1);
            iss_eof  = (rem_q == PW'(1));
        end
        if (lf_pop) begin
            rem_d    = lf_head;
            m_len_d  = lf_head[ADDR_W-1:0];
            rstate_d = R_LOAD;
        end
        lf_rp_d = lf_rp_q + LW'(lf_pop);
    end

    always_comb begin
        out_load = !m_vld_q || pop_out;
        m_vld_d  = m_vld_q;
        m_sof_d  = m_sof_q;
        m_eof_d  = m_eof_q;
        m_dat_d  = m_dat_q;
        sk_vld_d = sk_vld_q;
        sk_sof_d = sk_sof_q;
        sk_eof_d = sk_eof_q;
        sk_dat_d = sk_dat_q;
        if (out_load) begin
            if (sk_vld_q) begin
                m_vld_d  = 1'b1;
                m_sof_d  = sk_sof_q;
                m_eof_d  = sk_eof_q;
                m_dat_d  = sk_dat_q;
                sk_vld_d = pend_q;
                sk_sof_d = pend_sof_q;
                sk_eof_d = pend_eof_q;
                sk_dat_d = ram_q;
            end else if (pend_q) begin
                m_vld_d = 1'b1;
                m_sof_d = pend_sof_q;
                m_eof_d = pend_eof_q;
                m_dat_d = ram_q;
            end else begin
                m_vld_d = 1'b0;
                m_sof_d = 1'b0;
                m_eof_d = 1'b0;
            end
        end else if (pend_q) begin
            sk_vld_d = 1'b1;
            sk_sof_d = pend_sof_q;
            sk_eof_d = pend_eof_q;
            sk_dat_d = ram_q;
        end
    end

    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q   <= W_IDLE;
            wr_ptr_q   <= '0;
            wr_cmt_q   <= '0;
            flen_q     <= '0;
            crc_q      <= CRC_INIT;
            ok_q       <= '0;
            drop_q     <= '0;
            lf_wp_q    <= '0;
            lf_rp_q    <= '0;
            rstate_q   <= R_IDLE;
            rd_ptr_q   <= '0;
            rem_q      <= '0;
            m_len_q    <= '0;
            pend_q     <= 1'b0;
            pend_sof_q <= 1'b0;
            pend_eof_q <= 1'b0;
            sk_vld_q   <= 1'b0;
            sk_sof_q   <= 1'b0;
            sk_eof_q   <= 1'b0;
            m_vld_q    <= 1'b0;
            m_sof_q    <= 1'b0;
            m_eof_q    <= 1'b0;
            m_dat_q    <= '0;
        end else begin
            wstate_q   <= wstate_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_cmt_q   <= wr_cmt_d;
            flen_q     <= flen_d;
            crc_q      <= crc_d;
            ok_q       <= ok_d;
            drop_q     <= drop_d;
            lf_wp_q    <= lf_wp_d;
            lf_rp_q    <= lf_rp_d;
            rstate_q   <= rstate_d;
            rd_ptr_q   <= rd_ptr_d;
            rem_q      <= rem_d;
            m_len_q    <= m_len_d;
            pend_q     <= issue;
            pend_sof_q <= iss_sof;
            pend_eof_q <= iss_eof;
            sk_vld_q   <= sk_vld_d;
            sk_sof_q   <= sk_sof_d;
            sk_eof_q   <= sk_eof_d;
            m_vld_q    <= m_vld_d;
            m_sof_q    <= m_sof_d;
            m_eof_q    <= m_eof_d;
            m_dat_q    <= m_dat_d;
        end
    end

    always_ff @(posedge clk_mac) begin
        if (wr_en) mem[wr_addr] <= rx_dat;
        if (issue) ram_q <= mem[rd_ptr_q[ADDR_W-1:0]];
        if (push) lf_mem[lf_wp_q[LEN_W-1:0]] <= push_len;
        sk_dat_q <= sk_dat_d;
    end

    assign m_vld    = m_vld_q;
    assign m_dat    = m_dat_q;
    assign m_sof    = m_sof_q;
    assign m_eof    = m_eof_q;
    assign m_len    = m_len_q;
    assign cnt_ok   = ok_q;
    assign cnt_drop = drop_q;
endmodule

// File: tb/tb_eth_rx_frame_buf.sv
// Scoreboard bench for eth_rx_frame_buf: builds CRC-correct frames, queues expected output bytes.
`timescale 1ns/1ps
module tb_eth_rx_frame_buf;
    logic        clk_mac = 1'b0;
    logic        rst_n, rx_vld, rx_sof, rx_eof, m_rdy;
    logic [7:0]  rx_dat;
    logic        m_vld, m_sof, m_eof;
    logic [7:0]  m_dat;
    logic [10:0] m_len;
    logic [15:0] cnt_ok, cnt_drop;

    eth_rx_frame_buf dut (
        .clk_mac(clk_mac), .rst_n(rst_n),
        .rx_vld(rx_vld), .rx_dat(rx_dat), .rx_sof(rx_sof), .rx_eof(rx_eof),
        .m_vld(m_vld), .m_dat(m_dat), .m_sof(m_sof), .m_eof(m_eof), .m_len(m_len),
        .m_rdy(m_rdy), .cnt_ok(cnt_ok), .cnt_drop(cnt_drop)
    );

    always #10 clk_mac = ~clk_mac;

    typedef struct packed {
        logic [7:0]  dat;
        logic        sof;
        logic        eof;
        logic [10:0] len;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         n_out, n_sof, n_eof;
    logic [7:0] fbuf [0:2047];
    bit         tog_en;

    // Output monitor: every valid byte must match the head of the expected queue, stalled or not.
    always @(negedge clk_mac) begin
        if (rst_n === 1'b1 && m_vld === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got dat=%h sof=%b eof=%b", m_dat, m_sof, m_eof);
            end else begin
                if ({m_dat, m_sof, m_eof, m_len} !== {exp_q[0].dat, exp_q[0].sof, exp_q[0].eof, exp_q[0].len}) begin
                    errors++;
                    $display("FAIL out_byte got dat=%h sof=%b eof=%b len=%0d want dat=%h sof=%b eof=%b len=%0d",
                             m_dat, m_sof, m_eof, m_len, exp_q[0].dat, exp_q[0].sof, exp_q[0].eof, exp_q[0].len);
                end
                if (m_rdy) begin
                    void'(exp_q.pop_front());
                    n_out++;
                    if (m_sof) n_sof++;
                    if (m_eof) n_eof++;
                end
            end
        end
    end

    function automatic logic [31:0] ref_crc(input int len);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < len; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ fbuf[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return c;
    endfunction

    task automatic build_frame(input int len, input bit corrupt);
        logic [31:0] fcs;
        for (int i = 0; i < len - 4; i++) fbuf[i] = 8'($urandom);
        fcs = ~ref_crc(len - 4);
        fbuf[len-4] = fcs[7:0];
        fbuf[len-3] = fcs[15:8];
        fbuf[len-2] = fcs[23:16];
        fbuf[len-1] = fcs[31:24];
        if (corrupt) fbuf[len-4][0] = ~fbuf[len-4][0];
    endtask

    task automatic push_expect(input int len);
        exp_t e;
        for (int i = 0; i < len - 4; i++) begin
            e.dat = fbuf[i];
            e.sof = (i == 0);
            e.eof = (i == len - 5);
            e.len = 11'(len - 4);
            exp_q.push_back(e);
        end
    endtask

    // Drives nbytes of the frame in fbuf; eof is only flagged when the whole frame is sent.
    task automatic drive_frame(input int len, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            @(posedge clk_mac);
            #1;
            rx_vld = 1'b1;
            rx_dat = fbuf[i];
            rx_sof = (i == 0);
            rx_eof = (i == len - 1);
        end
    endtask

    task automatic rx_idle();
        @(posedge clk_mac);
        #1;
        rx_vld = 1'b0;
        rx_sof = 1'b0;
        rx_eof = 1'b0;
        rx_dat = 8'h00;
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        rx_vld = 1'b0;
        rx_sof = 1'b0;
        rx_eof = 1'b0;
        rx_dat = 8'h00;
        repeat (3) @(posedge clk_mac);
        #1;
        exp_q.delete();
        n_out = 0;
        n_sof = 0;
        n_eof = 0;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_vld) && n < budget) begin
            @(posedge clk_mac);
            n++;
        end
        repeat (4) @(posedge clk_mac);
        #1;
        ok = (n < budget);
    endtask

    task automatic test_reset();
        m_rdy = 1'b1;
        apply_reset();
        checks++;
        if ({m_vld, m_sof, m_eof, m_dat, m_len, cnt_ok, cnt_drop} !== '0) begin
            errors++;
            $display("FAIL reset_state got vld=%b sof=%b eof=%b dat=%h len=%0d ok=%0d drop=%0d want all 0",
                     m_vld, m_sof, m_eof, m_dat, m_len, cnt_ok, cnt_drop);
        end
    endtask

    task automatic test_good_frame();
        bit ok;
        apply_reset();
        m_rdy = 1'b1;
        build_frame(64, 1'b0);
        push_expect(64);
        drive_frame(64, 64);
        rx_idle();
        wait_drain(500, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL good_drain got timeout want drained"); end
        checks++;
        if (n_out != 60 || n_sof != 1 || n_eof != 1) begin
            errors++;
            $display("FAIL good_count got out=%0d sof=%0d eof=%0d want 60/1/1", n_out, n_sof, n_eof);
        end
        checks++;
        if (cnt_ok !== 16'd1 || cnt_drop !== 16'd0) begin
            errors++;
            $display("FAIL good_cnt got ok=%0d drop=%0d want 1/0", cnt_ok, cnt_drop);
        end
    endtask

    task automatic test_bad_fcs();
        int free;
        apply_reset();
        m_rdy = 1'b1;
        build_frame(64, 1'b1);
        drive_frame(64, 64);
        rx_idle();
        repeat (50) @(posedge clk_mac);
        #1;
        checks++;
        if (m_vld !== 1'b0 || n_out != 0) begin
            errors++;
            $display("FAIL badfcs_out got vld=%b out=%0d want 0/0", m_vld, n_out);
        end
        checks++;
        if (cnt_drop !== 16'd1 || cnt_ok !== 16'd0) begin
            errors++;
            $display("FAIL badfcs_cnt got ok=%0d drop=%0d want 0/1", cnt_ok, cnt_drop);
        end
        free = 2048 - int'(12'(dut.wr_ptr_q - dut.rd_ptr_q));
        checks++;
        if (free != 2048) begin
            errors++;
            $display("FAIL badfcs_free got %0d want 2048", free);
        end
    endtask

    task automatic test_runt();
        bit ok;
        apply_reset();
        m_rdy = 1'b1;
        build_frame(32, 1'b0);
        drive_frame(32, 32);
        rx_idle();
        repeat (10) @(posedge clk_mac);
        #1;
        checks++;
        if (cnt_drop !== 16'd1 || cnt_ok !== 16'd0) begin
            errors++;
            $display("FAIL runt_cnt got ok=%0d drop=%0d want 0/1", cnt_ok, cnt_drop);
        end
        fbuf[0] = 8'hA5;
        drive_frame(1, 1);
        rx_idle();
        repeat (5) @(posedge clk_mac);
        #1;
        checks++;
        if (cnt_drop !== 16'd2 || m_vld !== 1'b0) begin
            errors++;
            $display("FAIL runt_onebyte got drop=%0d vld=%b want 2/0", cnt_drop, m_vld);
        end
        build_frame(64, 1'b0);
        push_expect(64);
        drive_frame(64, 64);
        rx_idle();
        wait_drain(500, ok);
        checks++;
        if (!ok || n_out != 60 || cnt_ok !== 16'd1) begin
            errors++;
            $display("FAIL runt_then_good got ok_drain=%b out=%0d cnt_ok=%0d want 1/60/1", ok, n_out, cnt_ok);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        apply_reset();
        m_rdy = 1'b0;
        build_frame(1518, 1'b0);
        push_expect(1518);
        drive_frame(1518, 1518);
        build_frame(1518, 1'b0);
        drive_frame(1518, 1518);
        rx_idle();
        repeat (10) @(posedge clk_mac);
        #1;
        checks++;
        if (cnt_ok !== 16'd1 || cnt_drop !== 16'd1) begin
            errors++;
            $display("FAIL ovf_cnt got ok=%0d drop=%0d want 1/1", cnt_ok, cnt_drop);
        end
        m_rdy = 1'b1;
        wait_drain(5000, ok);
        checks++;
        if (!ok || n_out != 1514 || n_eof != 1) begin
            errors++;
            $display("FAIL ovf_out got ok_drain=%b out=%0d eof=%0d want 1/1514/1", ok, n_out, n_eof);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lens[3] = '{64, 100, 70};
        apply_reset();
        m_rdy  = 1'b1;
        tog_en = 1'b1;
        fork
            begin
                while (tog_en) begin
                    @(posedge clk_mac);
                    #1;
                    m_rdy = ~m_rdy;
                end
            end
        join_none
        for (int f = 0; f < 3; f++) begin
            build_frame(lens[f], 1'b0);
            push_expect(lens[f]);
            drive_frame(lens[f], lens[f]);
        end
        rx_idle();
        wait_drain(3000, ok);
        tog_en = 1'b0;
        repeat (2) @(posedge clk_mac);
        #1;
        m_rdy = 1'b1;
        checks++;
        if (!ok || n_out != 222) begin
            errors++;
            $display("FAIL b2b_out got ok_drain=%b out=%0d want 1/222", ok, n_out);
        end
        checks++;
        if (n_sof != 3 || n_eof != 3 || cnt_ok !== 16'd3) begin
            errors++;
            $display("FAIL b2b_marks got sof=%0d eof=%0d ok=%0d want 3/3/3", n_sof, n_eof, cnt_ok);
        end
    endtask

    task automatic test_sof_abort_and_reset();
        bit ok;
        int n;
        apply_reset();
        m_rdy = 1'b1;
        build_frame(64, 1'b0);
        drive_frame(64, 20);
        build_frame(64, 1'b0);
        push_expect(64);
        drive_frame(64, 64);
        rx_idle();
        wait_drain(500, ok);
        checks++;
        if (!ok || n_out != 60 || cnt_ok !== 16'd1 || cnt_drop !== 16'd1) begin
            errors++;
            $display("FAIL abort got ok_drain=%b out=%0d ok=%0d drop=%0d want 1/60/1/1",
                     ok, n_out, cnt_ok, cnt_drop);
        end
        build_frame(64, 1'b0);
        push_expect(64);
        drive_frame(64, 64);
        rx_idle();
        n = 0;
        while (m_vld !== 1'b1 && n < 100) begin
            @(posedge clk_mac);
            #1;
            n++;
        end
        checks++;
        if (n >= 100) begin errors++; $display("FAIL rst_wait got no m_vld want m_vld=1"); end
        @(negedge clk_mac);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_vld !== 1'b0 || cnt_ok !== 16'd0 || cnt_drop !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid got vld=%b ok=%0d drop=%0d want 0/0/0", m_vld, cnt_ok, cnt_drop);
        end
        exp_q.delete();
        @(posedge clk_mac);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        m_rdy  = 1'b1;
        tog_en = 1'b0;
        n_out  = 0;
        n_sof  = 0;
        n_eof  = 0;
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_runt();
        test_overflow();
        test_back_to_back();
        test_sof_abort_and_reset();
        repeat (5) @(posedge clk_mac);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
